// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the parameterised register file
package regfile_pkg;

  localparam int REGFILE_XLEN  = 32;
  localparam int REGFILE_NREGS = 32;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// rtl/regfile_scrub_ctrl.sv - scrub/run sequencer: owns state, scrub pointer, busy and clr_done
module regfile_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = REGFILE_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic [AW-1:0] ptr
);

  // Entry 0 is hardwired to zero, so the scrub only walks 1..NREGS-1.
  localparam logic [AW-1:0] PTR_FIRST = AW'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

  regfile_state_e state_q;
  regfile_state_e state_d;
  logic [AW-1:0]  ptr_d;
  logic           clr_done_d;

  // State, pointer and completion pulse registers; reset always restarts a full scrub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCRUB;
      ptr      <= PTR_FIRST;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr      <= ptr_d;
      clr_done <= clr_done_d;
    end
  end

  // Next-state logic: SCRUB steps the pointer to the last entry, RUN waits for clr_req.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr;
    clr_done_d = 1'b0;
    busy       = 1'b0;
    case (state_q)
      SCRUB: begin
        busy  = 1'b1;
        ptr_d = ptr + AW'(1);
        if (ptr == PTR_LAST) begin
          state_d    = RUN;
          ptr_d      = PTR_FIRST;
          clr_done_d = 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = SCRUB;
          ptr_d   = PTR_FIRST;
        end
      end
      default: begin
        state_d = SCRUB;
        ptr_d   = PTR_FIRST;
      end
    endcase
  end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised 2-write/NRD-read register file with scrub; optional REGFILE_BYPASS_EN forwarding
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN  = REGFILE_XLEN,
  parameter int NREGS = REGFILE_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                clr_req,
  output logic                busy,
  output logic                clr_done
);

  logic [XLEN-1:0] mem [NREGS];
  logic [AW-1:0]   scrub_ptr;
  logic            wen0;
  logic            wen1;

  regfile_scrub_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scrub_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .ptr      (scrub_ptr)
  );

  assign wen0 = we0 && (wa0 != '0) && !busy;
  assign wen1 = we1 && (wa1 != '0) && !busy;

  // Storage update: scrub writes zero at the pointer; otherwise port 1 is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[scrub_ptr] <= '0;
    end else begin
      if (wen0) mem[wa0] <= wd0;
      if (wen1) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = ra[k*AW +: AW];

    // Read mux per port: entry 0 and the whole scrub window read as zero.
    always_comb begin
      val = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wen1 && (wa1 == addr)) begin
        val = wd1;
      end else if (wen0 && (wa0 == addr)) begin
        val = wd0;
      end
`endif
      if (busy || (addr == '0)) begin
        val = '0;
      end
    end

    assign rd[k*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (vector table plus scoreboard)
module tb_regfile_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                clr_req;
  logic                busy;
  logic                clr_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   rchk;
    logic [XLEN-1:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];

  regfile_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rdp(input int k);
    return rd[k*XLEN +: XLEN];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  task automatic idle_writes();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Called just after a negedge with the first busy cycle visible; counts busy cycles and clr_done pulses.
  task automatic scrub_measure(input string tag, input bit inject);
    int cnt;
    int pulses;
    cnt    = 0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1) cnt++;
      if (clr_done === 1'b1) pulses++;
      if (inject) begin
        if (i == 2) begin
          set_ra(0, 5'd31);
          #1 chk({tag, "_busy_read"}, rdp(0), '0);
        end
        if (i == 4) begin we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h7777_7777; end
        if (i == 5) idle_writes();
        if (i == 8) clr_req = 1'b1;
        if (i == 9) clr_req = 1'b0;
      end
      @(negedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, cnt, 31);
    chk({tag, "_done_pulses"}, pulses, 1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      set_ra(0, AW'(a));
      set_ra(1, AW'(a + 16));
      #1;
      chk($sformatf("%s_x%0d", tag, a), rdp(0), '0);
      chk($sformatf("%s_x%0d", tag, a + 16), rdp(1), '0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         5'd5,  32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd7,  32'h2222_2222, 5'd7,  32'h2222_2222};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h1234_5678, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd11, 32'h0000_0055, 5'd10, 32'h0000_00AA};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd11, 32'h0000_0055};
    vecs[6] = '{1'b1, 5'd31, 32'h8000_0001, 1'b0, 5'd0,  32'h0,         5'd31, 32'h8000_0001};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  32'hCAFE_F00D, 5'd1,  32'hCAFE_F00D};
    vecs[8] = '{1'b0, 5'd5,  32'h0BAD_0BAD, 1'b0, 5'd5,  32'h0BAD_0BAD, 5'd5,  32'hDEAD_BEEF};

    rst_n   = 1'b0;
    clr_req = 1'b0;
    ra      = '0;
    idle_writes();
    set_ra(0, 5'd5);
    set_ra(1, 5'd6);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_rd0", rdp(0), '0);
    chk("rst_rd1", rdp(1), '0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    scrub_measure("init", 1'b0);
    check_all_zero("init_zero");

    foreach (vecs[i]) begin
      @(negedge clk);
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      sbq.push_back('{vecs[i].rchk, vecs[i].exp});
      @(negedge clk);
      idle_writes();
      begin
        exp_t e;
        e = sbq.pop_front();
        set_ra(0, e.a);
        set_ra(1, e.a);
        #1;
        chk($sformatf("vec%0d_p0", i), rdp(0), e.d);
        chk($sformatf("vec%0d_p1", i), rdp(1), e.d);
      end
    end

    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5_A5A5;
    set_ra(0, 5'd0);
    set_ra(1, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", rdp(1), 32'hA5A5_A5A5);
`else
    chk("byp_same_cycle", rdp(1), 32'h0);
`endif
    chk("byp_x0_read", rdp(0), '0);
    @(negedge clk);
    idle_writes();
    #1;
    chk("byp_next_cycle", rdp(1), 32'hA5A5_A5A5);

    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h0BAD_0000;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0600_D000;
    set_ra(0, 5'd12);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_prio", rdp(0), 32'h0600_D000);
`else
    chk("byp_prio", rdp(0), 32'h0);
`endif
    @(negedge clk);
    idle_writes();
    #1;
    chk("prio_stored", rdp(0), 32'h0600_D000);

    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      idle_writes();
      if (i % 2 == 1) begin
        we1 = 1'b1; wa1 = AW'(i); wd1 = 32'hC000_0000 + i;
      end else begin
        we0 = 1'b1; wa0 = AW'(i); wd0 = 32'hC000_0000 + i;
      end
      sbq.push_back('{AW'(i), 32'hC000_0000 + i});
    end
    @(negedge clk);
    idle_writes();
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      set_ra(0, e.a);
      #1;
      chk($sformatf("fill_x%0d", e.a), rdp(0), e.d);
      @(negedge clk);
    end

    clr_req = 1'b1;
    @(negedge clk);
    #1;
    clr_req = 1'b0;
    scrub_measure("clr", 1'b1);
    check_all_zero("clr_zero");

    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h4444_4444;
    @(negedge clk);
    idle_writes();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_done", clr_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    scrub_measure("midrst", 1'b0);
    check_all_zero("midrst_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
